// File: rtl/dmem_responder.sv
// Single-port data memory that answers one load/store at a time after a fixed
// number of wait states, flagging misaligned or out-of-range word addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_a_write;
  logic [31:0]      w_a_addr;
  logic [31:0]      w_a_wdata;
  logic [3:0]       w_a_be;
  logic             w_a_err;
  logic [IDX_W-1:0] w_a_idx;

  // Handshakes: a request transfers on an edge with req_valid && req_ready,
  // a response on an edge with resp_valid && resp_ready; valid never drops
  // before its transfer and data/err stay stable while valid is high.
  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // With no wait states the access happens on the accepting edge itself,
  // so the request fields come straight from the inputs.
  assign w_a_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_a_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_a_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_a_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_a_err   = (w_a_addr[1:0] != 2'b00) || (w_a_addr[31:2] >= DEPTH_LIM);
  assign w_a_idx   = w_a_addr[IDX_W+1:2];

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_rdata <= (!w_a_write && !w_a_err) ? r_mem[w_a_idx] : 32'd0;
        r_err   <= w_a_err;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_enter_resp && w_a_write && !w_a_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_a_be[b]) r_mem[w_a_idx][8*b +: 8] <= w_a_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;
  logic [1:0]  z_dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .dbg_state(z_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be accepted on the next edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    check("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    req_write = 1'b1;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0BAD_0BAD;
    req_be    = 4'hF;
  endtask

  // Edges after the accepting edge until resp_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, resp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
    check({tag, "_rdata_idle"}, resp_rdata, 32'd0);
  endtask

  // Accepting edge counts as edge 1, so with two wait states valid is
  // first visible two edges after the one that accepted the request.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(w, a, d, be);
    check({tag, "_no_early_valid"}, resp_valid, 0);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, resp_err, exp_err);
    complete(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", resp_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;

    // Full store, read back; partial byte-enable merge; empty byte-enable.
    txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    txn("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn("st_be5", 1'b1, 32'h10, 32'h11223344, 4'h5, 32'd0, 1'b0);
    txn("ld_merge", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    txn("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
    txn("ld_after_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    // Errors: misaligned, just past the end, high bits set; none may write.
    txn("ld_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 32'd0, 1'b1);
    txn("ld_range", 1'b0, 32'h400, 32'h0, 4'h0, 32'd0, 1'b1);
    txn("st_misalign", 1'b1, 32'h12, 32'h55555555, 4'hF, 32'd0, 1'b1);
    txn("st_range", 1'b1, 32'h400, 32'h77777777, 4'hF, 32'd0, 1'b1);
    txn("st_highbit", 1'b1, 32'h80000010, 32'h99999999, 4'hF, 32'd0, 1'b1);
    txn("ld_word0", 1'b0, 32'h0, 32'h0, 4'h0, 32'd0, 1'b0);
    txn("ld_unchanged", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    txn("st_last", 1'b1, 32'h3FC, 32'hA5A5C3C3, 4'hF, 32'd0, 1'b0);
    txn("ld_last", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hA5A5C3C3, 1'b0);

    // Backpressure: hold the response while a competing store is offered.
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd2);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", resp_valid, 1);
      check("bp_rdata_hold", resp_rdata, 32'hDE22BE44);
      check("bp_err_hold", resp_err, 0);
      check("bp_req_ready_low", req_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_state_idle", dbg_state, 0);
    check("bp_req_ready_back", req_ready, 1);
    txn("ld_after_bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    // Reset during the wait states of a store.
    issue(1'b1, 32'h20, 32'hAAAA5555, 4'hF);
    step();
    check("mid_state_wait", dbg_state, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    txn("ld_after_rst_20", 1'b0, 32'h20, 32'h0, 4'h0, 32'd0, 1'b0);
    txn("ld_after_rst_10", 1'b0, 32'h10, 32'h0, 4'h0, 32'd0, 1'b0);

    // No wait states: response visible right after the accepting edge.
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8;
    z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF; z_resp_ready = 1'b1;
    check("z_ready_idle", z_req_ready, 1);
    step();
    z_req_valid = 1'b0;
    check("z_st_valid", z_resp_valid, 1);
    check("z_st_err", z_resp_err, 0);
    check("z_st_rdata", z_resp_rdata, 32'd0);
    check("z_st_state", z_dbg_state, 2);
    step();
    check("z_st_done", z_resp_valid, 0);
    check("z_st_ready", z_req_ready, 1);

    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h8; z_req_be = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("z_b2b_valid", z_resp_valid, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("z_b2b_rdata", z_resp_rdata, (i % 2 == 0) ? 32'hCAFEF00D : 32'd0);
    end
    z_req_valid = 1'b0;
    z_resp_ready = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
